// File: rtl/adcmux_scan.sv
// N:1 ADC input multiplexer with scan sequencer: walks an enabled-channel mask,
// waits a programmable settle time per channel and handshakes one conversion each.
module adcmux_scan #(
    parameter int NCH      = 8,
    parameter int SELW     = $clog2(NCH),
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      vin,
    input  logic [NCH-1:0]      ch_en,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic                mode,
    input  logic                start,
    input  logic                stop,
    output logic [SELW-1:0]     sel,
    output logic                vout,
    output logic                conv_req,
    input  logic                conv_ack,
    output logic                sample_valid,
    output logic [SELW-1:0]     sample_ch,
    output logic                sample_data,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, SETTLE, CONV} state_t;

    state_t              state;
    logic [NCH-1:0]      mask_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] cnt;
    logic                mode_q;
    logic                go;
    logic                stop_pend;
    logic [SELW-1:0]     nxt_ch;
    logic                nxt_wrap;

    function automatic logic [SELW-1:0] lowest(input logic [NCH-1:0] m);
        lowest = '0;
        for (int unsigned i = NCH; i > 0; i--)
            if (m[i-1]) lowest = SELW'(i - 1);
    endfunction

    // Next enabled channel above sel; nxt_wrap flags end of pass.
    always_comb begin
        nxt_ch   = lowest(mask_q);
        nxt_wrap = 1'b1;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (mask_q[i-1] && ((i - 1) > 32'(sel))) begin
                nxt_ch   = SELW'(i - 1);
                nxt_wrap = 1'b0;
            end
        end
    end

    assign vout = (int'(sel) < NCH) ? vin[sel] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= '0;
            conv_req     <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            stop_pend    <= 1'b0;
            go           <= 1'b0;
            cnt          <= '0;
            mask_q       <= '0;
            settle_q     <= '0;
            mode_q       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            if (busy && stop) stop_pend <= 1'b1;

            case (state)
                // Start is two-step: the edge that sees start latches the
                // configuration, the following edge acts on the latched mask.
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (go) begin
                        go <= 1'b0;
                        if (mask_q != '0) begin
                            sel   <= lowest(mask_q);
                            cnt   <= settle_q;
                            busy  <= 1'b1;
                            state <= SETTLE;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (start) begin
                        mask_q   <= ch_en;
                        settle_q <= settle_cyc;
                        mode_q   <= mode;
                        go       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        conv_req <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (conv_ack) begin
                        conv_req     <= 1'b0;
                        sample_valid <= 1'b1;
                        sample_ch    <= sel;
                        sample_data  <= vout;
                        if (nxt_wrap && (!mode_q || stop_pend)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            sel   <= nxt_ch;
                            cnt   <= settle_q;
                            state <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
